// File: rtl/hall_pkg.sv
// rtl/hall_pkg.sv - Hall commutation sequence, step decode and saturating add helpers
package hall_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ILL  = 2'd3
    } step_t;

    // Forward commutation order; reverse is the same ring walked backwards.
    localparam logic [2:0] HALL_S0 = 3'b001;
    localparam logic [2:0] HALL_S1 = 3'b011;
    localparam logic [2:0] HALL_S2 = 3'b010;
    localparam logic [2:0] HALL_S3 = 3'b110;
    localparam logic [2:0] HALL_S4 = 3'b100;
    localparam logic [2:0] HALL_S5 = 3'b101;

    function automatic logic code_legal(input logic [2:0] c);
        return (c != 3'b000) && (c != 3'b111);
    endfunction

    function automatic logic [2:0] fwd_next(input logic [2:0] c);
        case (c)
            HALL_S0: return HALL_S1;
            HALL_S1: return HALL_S2;
            HALL_S2: return HALL_S3;
            HALL_S3: return HALL_S4;
            HALL_S4: return HALL_S5;
            HALL_S5: return HALL_S0;
            default: return 3'b000;
        endcase
    endfunction

    function automatic step_t step_decode(input logic [2:0] prev, input logic [2:0] s);
        if (!code_legal(s))            return STEP_ILL;
        if (s == prev)                 return STEP_NONE;
        if (fwd_next(prev) == s)       return STEP_FWD;
        if (fwd_next(s) == prev)       return STEP_REV;
        return STEP_ILL;
    endfunction

    // Symmetric clamp: the most negative code is never produced.
    function automatic int sat_add(input int acc, input int delta, input int width);
        int lim;
        int sum;
        lim = (1 << (width - 1)) - 1;
        sum = acc + delta;
        if (sum > lim)  return lim;
        if (sum < -lim) return -lim;
        return sum;
    endfunction

endpackage

// File: rtl/hall_channel.sv
// rtl/hall_channel.sv - one Hall channel: synchroniser, step decode, accumulator, flags
module hall_channel
    import hall_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       h,
    input  logic             clr,
    input  logic             term,
    output logic [CNT_W-1:0] speed,
    output logic             dir,
    output logic             fault
);

    logic [2:0]              sync_q [SYNC_STG];
    logic [2:0]              s;
    logic [2:0]              prev;
    logic                    primed;
    logic signed [CNT_W-1:0] acc;
    logic signed [CNT_W-1:0] acc_next;
    step_t                   st;
    int                      delta;
    int                      acc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STG; i++) sync_q[i] <= 3'b000;
        end else begin
            sync_q[0] <= h;
            for (int i = 1; i < SYNC_STG; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STG-1];

    always_comb begin
        st      = primed ? step_decode(prev, s) : STEP_NONE;
        delta   = 0;
        if (st == STEP_FWD) delta = 1;
        if (st == STEP_REV) delta = -1;
        acc_sum  = sat_add(int'(acc), delta, CNT_W);
        acc_next = acc_sum[CNT_W-1:0];
    end

    // Priming waits for a legal code so the zeroed synchroniser never looks like a fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed <= 1'b0;
            prev   <= 3'b000;
            acc    <= '0;
            speed  <= '0;
            dir    <= 1'b0;
            fault  <= 1'b0;
        end else if (clr) begin
            primed <= 1'b0;
            acc    <= '0;
            speed  <= '0;
            dir    <= 1'b0;
            fault  <= 1'b0;
        end else begin
            if (!primed) begin
                if (code_legal(s)) begin
                    prev   <= s;
                    primed <= 1'b1;
                end
            end else begin
                case (st)
                    STEP_FWD: begin
                        prev <= s;
                        dir  <= 1'b1;
                    end
                    STEP_REV: begin
                        prev <= s;
                        dir  <= 1'b0;
                    end
                    STEP_ILL: begin
                        fault <= 1'b1;
                        if (code_legal(s)) prev <= s;
                    end
                    default: ;
                endcase
            end
            if (term) begin
                speed <= acc_next;
                acc   <= '0;
            end else begin
                acc   <= acc_next;
            end
        end
    end

endmodule

// File: rtl/hall_speed_meter.sv
// rtl/hall_speed_meter.sv - multi-channel Hall speed/direction meter with fixed gate window
module hall_speed_meter
    import hall_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CNT_W    = 8,
    parameter int GATE_CYC = 3500000,
    parameter int GATE_W   = 22,
    parameter int SYNC_STG = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [3*NCH-1:0]     H,
    input  logic                 clr,
    output logic [NCH*CNT_W-1:0] speed,
    output logic [NCH-1:0]       dir,
    output logic [NCH-1:0]       fault,
    output logic                 valid
);

    localparam logic [GATE_W-1:0] TERM_CNT = GATE_W'(GATE_CYC - 1);

    logic [GATE_W-1:0] win_cnt;
    logic              term;

    assign term = (win_cnt == TERM_CNT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            win_cnt <= '0;
            valid   <= 1'b0;
        end else if (clr) begin
            win_cnt <= '0;
            valid   <= 1'b0;
        end else begin
            valid   <= term;
            win_cnt <= term ? '0 : win_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        hall_channel #(
            .CNT_W    (CNT_W),
            .SYNC_STG (SYNC_STG)
        ) u_ch (
            .clk   (CLK),
            .rst_n (RST),
            .h     (H[3*i +: 3]),
            .clr   (clr),
            .term  (term),
            .speed (speed[CNT_W*i +: CNT_W]),
            .dir   (dir[i]),
            .fault (fault[i])
        );
    end

endmodule
